// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and helpers for the cascaded counter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Force an out-of-range nibble to the largest legal decimal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

  // Decimal digit k of val (k = 0 is the units digit); supports up to 8 digits.
  function automatic bcd_digit_t bcd_reset_digit(input int unsigned val, input int unsigned k);
    int unsigned v;
    v = val;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < k) v = v / 10;
    end
    return bcd_digit_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control and status bundle of the BCD counter chain.
interface bcd_counter_chain_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  logic             en;
  logic             up_dn;
  logic             load;
  logic [BCD_W-1:0] load_val;
  logic [BCD_W-1:0] bcd;
  logic             count;
  logic             wrap;

  modport master (output en, up_dn, load, load_val, input bcd, count, wrap);
  modport slave  (input en, up_dn, load, load_val, output bcd, count, wrap);
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: reset/load/step register plus its direction-dependent limit flag.
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RST_DIGIT = BCD_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step,
  input  logic       up_dn,
  output bcd_digit_t digit,
  output logic       at_limit
);

  bcd_digit_t digit_q;

  // Digit register: reset > load > step, wrapping 9->0 up and 0->9 down.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= RST_DIGIT;
    end else if (load) begin
      digit_q <= bcd_clamp(load_digit);
    end else if (step) begin
      if (up_dn) digit_q <= (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else       digit_q <= (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  assign digit    = digit_q;
  assign at_limit = up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with load, terminal count and wrap pulse.
// Optional build macro BCD_CNT_SATURATE_EN: counting holds at all-9s / all-0s
// instead of wrapping, and wrap is tied low.
module bcd_counter_chain
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned RESET_VAL  = 0
) (
  input logic                clk,
  input logic                reset,
  bcd_counter_chain_if.slave bus
);

  logic [NUM_DIGITS-1:0] at_limit;
  logic [NUM_DIGITS:0]   carry;
  logic                  all_limit;
  logic                  step_en;

  assign all_limit = &at_limit;
  assign bus.count = all_limit;

`ifdef BCD_CNT_SATURATE_EN
  // At the terminal value the whole chain stops instead of rolling over.
  assign step_en = bus.en & ~all_limit;
`else
  assign step_en = bus.en;
`endif

  assign carry[0] = step_en;

  // Digit k steps only when enabled and every lower digit sits at its limit.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_t digit;

    bcd_digit #(
      .RST_DIGIT (bcd_reset_digit(RESET_VAL, k))
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .load_digit (bus.load_val[DIGIT_W*k +: DIGIT_W]),
      .step       (carry[k]),
      .up_dn      (bus.up_dn),
      .digit      (digit),
      .at_limit   (at_limit[k])
    );

    assign carry[k+1]                       = carry[k] & at_limit[k];
    assign bus.bcd[DIGIT_W*k +: DIGIT_W]    = digit;
  end

`ifdef BCD_CNT_SATURATE_EN
  assign bus.wrap = 1'b0;
`else
  logic wrap_q;

  // Wrap pulse: set for the cycle after the chain rolls past its terminal value.
  always_ff @(posedge clk) begin
    if (reset || bus.load) wrap_q <= 1'b0;
    else                   wrap_q <= carry[NUM_DIGITS];
  end

  assign bus.wrap = wrap_q;
`endif

endmodule
